// File: rtl/hamming15_pkg.sv
// Shared definitions for the Hamming(15,11) link.
//   DATA_W/CODE_W/CNT_W : payload, codeword and bit-counter widths
//   PARITY_IDX          : codeword bits carrying parity (positions 1,2,4,8)
//   DATA_MAP            : codeword bit receiving d[i]
//   state_t             : serializer FSM states
//   hamming15_encode()  : even-parity encoder, also used by the decoder-side checker
package hamming15_pkg;

    localparam int DATA_W = 11;
    localparam int CODE_W = 15;
    localparam int CNT_W  = 4;

    localparam int PARITY_IDX [4]      = '{0, 1, 3, 7};
    localparam int DATA_MAP   [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

    function automatic logic [CODE_W-1:0] hamming15_encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] cw;
        logic              x;
        cw = '0;
        for (int i = 0; i < DATA_W; i++) cw[DATA_MAP[i]] = d[i];
        // Parity slots are still zero here, so XOR over every covered
        // position equals XOR over the covered data positions only.
        for (int p = 0; p < 4; p++) begin
            x = 1'b0;
            for (int k = 0; k < CODE_W; k++)
                if (((k + 1) & (PARITY_IDX[p] + 1)) != 0) x = x ^ cw[k];
            cw[PARITY_IDX[p]] = x;
        end
        return cw;
    endfunction

endpackage

// File: rtl/hamming15_tx_serializer_encode_comb.sv
// Purely combinational Hamming(15,11) parity generator.
//   data     : 11-bit payload
//   codeword : 15-bit even-parity codeword, bit k = Hamming position k+1
module hamming15_encode_comb
    import hamming15_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CODE_W-1:0] codeword
);

    assign codeword = hamming15_encode(data);

endmodule

// File: rtl/hamming15_tx_serializer.sv
// Transmit side of the Hamming(15,11) serial link: accepts an 11-bit word on
// a valid/ready handshake, encodes it and shifts the codeword out LSB first,
// one tx_shift strobe every BIT_PERIOD cycles, then idles INTER_WORD_GAP
// cycles before accepting the next word.
//   clk, reset           : clock, synchronous active-high reset
//   data_in/data_valid   : payload and its valid; data_ready = can accept
//   tx_bit/tx_shift      : serial bit and its one-cycle sample strobe
//   tx_busy              : acceptance through end of gap
//   tx_done              : pulse with the 15th strobe
//   codeword_out         : codeword of the word in flight
// Optional macro HAMMING15_ERR_INJECT_EN adds err_inject/err_pos to flip one
// codeword bit (err_pos 0..14; 15 = no flip) at the acceptance edge.
module hamming15_tx_serializer
    import hamming15_pkg::*;
#(
    parameter int BIT_PERIOD     = 1,
    parameter int INTER_WORD_GAP = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
`ifdef HAMMING15_ERR_INJECT_EN
    input  logic              err_inject,
    input  logic [CNT_W-1:0]  err_pos,
`endif
    output logic              data_ready,
    output logic              tx_bit,
    output logic              tx_shift,
    output logic              tx_busy,
    output logic              tx_done,
    output logic [CODE_W-1:0] codeword_out
);

    localparam int DIV_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int GAP_W = (INTER_WORD_GAP > 1) ? $clog2(INTER_WORD_GAP) : 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_SEND = SEND;
    localparam logic [1:0] S_GAP  = GAP;

    logic [1:0]        state;
    logic [CODE_W-1:0] sreg;
    logic [DIV_W-1:0]  div;
    logic [CNT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [CODE_W-1:0] enc_cw;
    logic [CODE_W-1:0] load_cw;

    hamming15_encode_comb u_enc (
        .data     (data_in),
        .codeword (enc_cw)
    );

`ifdef HAMMING15_ERR_INJECT_EN
    // err_pos == 15 selects no bit, so the word goes out unmodified.
    always_comb begin
        load_cw = enc_cw;
        if (err_inject && (err_pos != 4'hF))
            load_cw = enc_cw ^ (15'b1 << err_pos);
    end
`else
    assign load_cw = enc_cw;
`endif

    assign data_ready = (state == S_IDLE);
    assign tx_busy    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            sreg         <= '0;
            codeword_out <= '0;
            div          <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            tx_bit       <= 1'b0;
            tx_shift     <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            tx_shift <= 1'b0;
            tx_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (data_valid) begin
                        sreg         <= load_cw;
                        codeword_out <= load_cw;
                        div          <= '0;
                        bit_cnt      <= '0;
                        state        <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (div == DIV_W'(BIT_PERIOD - 1)) begin
                        div      <= '0;
                        tx_shift <= 1'b1;
                        tx_bit   <= sreg[0];
                        sreg     <= sreg >> 1;
                        bit_cnt  <= bit_cnt + 1'b1;
                        // bit_cnt ends at 15 and is only cleared on the next
                        // acceptance, so it never wraps.
                        if (bit_cnt == 4'd14) begin
                            tx_done <= 1'b1;
                            gap_cnt <= '0;
                            state   <= (INTER_WORD_GAP == 0) ? S_IDLE : S_GAP;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(INTER_WORD_GAP - 1)) state <= S_IDLE;
                    else                                      gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming15_tx_serializer.sv
module tb_hamming15_tx_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic [1:0][10:0]      din;
    logic [1:0]            dv;
    wire  [1:0]            rdy, tbit, tsh, busy, done;
    wire  [1:0][14:0]      cwo;
`ifdef HAMMING15_ERR_INJECT_EN
    logic [1:0]            einj;
    logic [1:0][3:0]       epos;
`endif

    // Instance 0: one cycle per bit, one gap cycle. Instance 1: 4 cycles per bit, no gap.
    hamming15_tx_serializer #(.BIT_PERIOD(1), .INTER_WORD_GAP(1)) u_dut_p1 (
        .clk(clk), .reset(reset), .data_in(din[0]), .data_valid(dv[0]),
`ifdef HAMMING15_ERR_INJECT_EN
        .err_inject(einj[0]), .err_pos(epos[0]),
`endif
        .data_ready(rdy[0]), .tx_bit(tbit[0]), .tx_shift(tsh[0]), .tx_busy(busy[0]),
        .tx_done(done[0]), .codeword_out(cwo[0]));

    hamming15_tx_serializer #(.BIT_PERIOD(4), .INTER_WORD_GAP(0)) u_dut_p4 (
        .clk(clk), .reset(reset), .data_in(din[1]), .data_valid(dv[1]),
`ifdef HAMMING15_ERR_INJECT_EN
        .err_inject(einj[1]), .err_pos(epos[1]),
`endif
        .data_ready(rdy[1]), .tx_bit(tbit[1]), .tx_shift(tsh[1]), .tx_busy(busy[1]),
        .tx_done(done[1]), .codeword_out(cwo[1]));

    // ---------------- monitor: behaves like the receiver ----------------
    int          cyc = 0;
    int          str_tot [2] = '{0, 0};
    int          done_tot[2] = '{0, 0};
    int          done_cyc[2] = '{0, 0};
    int          str_at_done[2] = '{0, 0};
    logic [14:0] rx_sr[2] = '{15'h0, 15'h0};
    int          str_cyc[2][0:2047];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (tsh[i]) begin
                rx_sr[i] <= {tbit[i], rx_sr[i][14:1]};
                str_cyc[i][str_tot[i] & 2047] <= cyc;
                str_tot[i] <= str_tot[i] + 1;
            end
            if (done[i]) begin
                done_tot[i]    <= done_tot[i] + 1;
                done_cyc[i]    <= cyc;
                str_at_done[i] <= str_tot[i] + (tsh[i] ? 1 : 0);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [14:0] ref_enc(input logic [10:0] d, input logic inj, input logic [3:0] pos);
        logic [14:0] cw;
        logic        x;
        int          di;
        cw = '0;
        di = 0;
        for (int p = 1; p <= 15; p++)
            if ((p & (p - 1)) != 0) begin cw[p-1] = d[di]; di++; end
        for (int b = 1; b <= 8; b = b * 2) begin
            x = 1'b0;
            for (int p = 1; p <= 15; p++) if ((p & b) != 0) x = x ^ cw[p-1];
            cw[b-1] = x;
        end
        if (inj && pos != 4'd15) cw[pos] = ~cw[pos];
        return cw;
    endfunction

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;
    int          bp[2] = '{1, 4};
    int          c0[2], base_str[2], base_done[2];
    logic [14:0] exp_cw[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input int i);
        chk("rst_ready", rdy[i], 1);
        chk("rst_tx_bit", tbit[i], 0);
        chk("rst_tx_shift", tsh[i], 0);
        chk("rst_busy", busy[i], 0);
        chk("rst_done", done[i], 0);
        chk("rst_codeword", cwo[i], 0);
    endtask

    task automatic start(input int i, input logic [10:0] d, input logic inj, input logic [3:0] pos);
        int n;
        n = 0;
        while (!rdy[i] && n < 100) begin step(); n++; end
        chk("ready_before_accept", rdy[i], 1);
        base_str[i]  = str_tot[i];
        base_done[i] = done_tot[i];
        din[i] = d;
        dv[i]  = 1'b1;
`ifdef HAMMING15_ERR_INJECT_EN
        einj[i] = inj;
        epos[i] = pos;
        exp_cw[i] = ref_enc(d, inj, pos);
`else
        exp_cw[i] = ref_enc(d, 1'b0, pos);
`endif
        step();
        c0[i] = cyc;
        dv[i]  = 1'b0;
        din[i] = 11'($urandom);
`ifdef HAMMING15_ERR_INJECT_EN
        einj[i] = 1'($urandom);
        epos[i] = 4'($urandom);
`endif
        chk("busy_after_accept", busy[i], 1);
        chk("ready_after_accept", rdy[i], 0);
        chk("codeword_loaded", cwo[i], exp_cw[i]);
    endtask

    task automatic finish_word(input int i);
        int n, bad;
        n = 0;
        bad = 0;
        while (done_tot[i] == base_done[i] && n < 300) begin step(); n++; end
        chk("done_seen", (done_tot[i] != base_done[i]) ? 1 : 0, 1);
        chk("strobes_at_done", str_at_done[i] - base_str[i], 15);
        chk("done_cycle", done_cyc[i] - c0[i], 15 * bp[i]);
        for (int k = 0; k < 15; k++)
            if (str_cyc[i][(base_str[i] + k) & 2047] != c0[i] + (k + 1) * bp[i]) bad++;
        chk("strobe_timing", bad, 0);
        chk("rx_assembled", rx_sr[i], exp_cw[i]);
        chk("codeword_held", cwo[i], exp_cw[i]);
        if (i == 0) begin
            chk("gap_ready_low", rdy[i], 0);
            chk("gap_busy_high", busy[i], 1);
            step();
            chk("after_gap_ready", rdy[i], 1);
            chk("after_gap_busy", busy[i], 0);
            chk("after_gap_done_low", done[i], 0);
        end else begin
            chk("nogap_ready", rdy[i], 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] w;
        int          n, sd;
        reset = 1'b1;
        dv    = '0;
        din   = '0;
`ifdef HAMMING15_ERR_INJECT_EN
        einj  = '0;
        epos  = '0;
`endif
        repeat (3) step();
        chk_reset_vals(0);
        chk_reset_vals(1);
        reset = 1'b0;
        step();

        // Directed words on the BIT_PERIOD=1 instance.
        start(0, 11'h000, 1'b0, 4'd15);
        chk("cw_000", cwo[0], 15'h0000);
        finish_word(0);
        start(0, 11'h001, 1'b0, 4'd15);
        chk("cw_001", cwo[0], 15'h0007);
        finish_word(0);
        start(0, 11'h400, 1'b0, 4'd15);
        chk("cw_400", cwo[0], 15'h408B);
        finish_word(0);
        start(0, 11'h7FF, 1'b0, 4'd15);
        chk("cw_7ff", cwo[0], 15'h7FFF);
        finish_word(0);

        // Random words.
        for (int r = 0; r < 8; r++) begin
            start(0, 11'($urandom), 1'b0, 4'd15);
            finish_word(0);
        end

        // BIT_PERIOD=4, no gap: data_valid during SEND is ignored, then back-to-back.
        start(1, 11'($urandom), 1'b0, 4'd15);
        for (int k = 0; k < 6; k++) begin
            dv[1]  = 1'b1;
            din[1] = 11'($urandom);
            step();
            chk("send_ignores_valid", rdy[1], 0);
        end
        dv[1] = 1'b0;
        finish_word(1);
        sd = done_cyc[1];
        start(1, 11'($urandom), 1'b0, 4'd15);
        chk("back_to_back_accept", c0[1] - sd, 1);
        finish_word(1);
        start(1, 11'($urandom), 1'b0, 4'd15);
        finish_word(1);

        // Reset mid-word after strobe 7.
        start(0, 11'($urandom), 1'b0, 4'd15);
        n = 0;
        while (str_tot[0] - base_str[0] < 7 && n < 100) begin step(); n++; end
        chk("reached_strobe7", str_tot[0] - base_str[0], 7);
        reset = 1'b1;
        step();
        chk_reset_vals(0);
        reset = 1'b0;
        sd = done_tot[0];
        repeat (30) step();
        chk("no_done_after_reset", done_tot[0] - sd, 0);
        w = 11'($urandom);
        start(0, w, 1'b0, 4'd15);
        finish_word(0);

`ifdef HAMMING15_ERR_INJECT_EN
        start(0, 11'h000, 1'b1, 4'd5);
        chk("inject_pos5", cwo[0], 15'h0020);
        finish_word(0);
        w = 11'($urandom);
        start(0, w, 1'b1, 4'd15);
        chk("inject_pos15_clean", cwo[0], ref_enc(w, 1'b0, 4'd0));
        finish_word(0);
        for (int r = 0; r < 4; r++) begin
            start(0, 11'($urandom), 1'($urandom), 4'($urandom));
            finish_word(0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
